// File: rtl/multiexp_feeder.sv
// ---------------------------------------------------------------------------
// multiexp_feeder
//
// Collects a batch of NUM_IN {point, scalar} pairs into a local buffer, then
// replays the whole batch SCL_BITS times towards the multi-exponentiation
// core: entries 0..NUM_IN-1 in order, one round per scalar bit. Every output
// beat is a single-beat packet (sop=eop=1) tagged with its entry index in ctl.
//
// Parameters
//   PNT_BITS : width of one Jacobian point (x,y,z)
//   SCL_BITS : width of one scalar, also the number of replay rounds
//   NUM_IN   : pairs per batch
//   CTL_BITS : control field width
//
// Ports
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_pnt_scl_*         : input stream (dat/val/rdy/sop/eop/ctl), dat={point,scalar}
//   o_pnt_scl_*         : output stream to the core, same widths
//   o_busy              : high while loading or replaying
//   o_err               : (MULTIEXP_FEEDER_ERR_EN only) sticky early-eop flag
//
// Configuration macro: MULTIEXP_FEEDER_ERR_EN
//   When defined, an input beat with eop=1 before the last entry of a batch
//   discards the partial batch and sets o_err until reset. When undefined,
//   input sop/eop/ctl are ignored and o_err does not exist.
// ---------------------------------------------------------------------------
module multiexp_feeder #(
  parameter int PNT_BITS = 768,
  parameter int SCL_BITS = 256,
  parameter int NUM_IN   = 4,
  parameter int CTL_BITS = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [PNT_BITS+SCL_BITS-1:0] i_pnt_scl_dat,
  input  logic                         i_pnt_scl_val,
  output logic                         i_pnt_scl_rdy,
  input  logic                         i_pnt_scl_sop,
  input  logic                         i_pnt_scl_eop,
  input  logic [CTL_BITS-1:0]          i_pnt_scl_ctl,
  output logic [PNT_BITS+SCL_BITS-1:0] o_pnt_scl_dat,
  output logic                         o_pnt_scl_val,
  input  logic                         o_pnt_scl_rdy,
  output logic                         o_pnt_scl_sop,
  output logic                         o_pnt_scl_eop,
  output logic [CTL_BITS-1:0]          o_pnt_scl_ctl,
`ifdef MULTIEXP_FEEDER_ERR_EN
  output logic                         o_err,
`endif
  output logic                         o_busy
);

  localparam int DAT_W = PNT_BITS + SCL_BITS;
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int RND_W = (SCL_BITS > 1) ? $clog2(SCL_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(SCL_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  load_cnt_r;
  logic [IDX_W-1:0]  ent_r;
  logic [RND_W-1:0]  rnd_r;
  logic [DAT_W-1:0]  mem_r [NUM_IN];

  logic              in_acc_s;
  logic              out_acc_s;
  logic              ent_last_s;
  logic              rnd_last_s;
  logic [IDX_W-1:0]  ent_nxt_s;
  logic              err_s;
  logic              unused_in_s;

  assign in_acc_s   = i_pnt_scl_val & i_pnt_scl_rdy;
  assign out_acc_s  = o_pnt_scl_val & o_pnt_scl_rdy;
  assign ent_last_s = (ent_r == LAST_IDX);
  assign rnd_last_s = (rnd_r == LAST_RND);
  assign o_busy     = (state_r != IDLE);

  // Input sideband carries no information for this block.
  assign unused_in_s = ^{i_pnt_scl_sop, i_pnt_scl_eop, i_pnt_scl_ctl};

`ifdef MULTIEXP_FEEDER_ERR_EN
  // An eop on any beat but the last one means the batch arrived short.
  assign err_s = i_pnt_scl_eop & (load_cnt_r != LAST_IDX);

  // Sticky error flag, only reset clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (in_acc_s && err_s) begin
      o_err <= 1'b1;
    end
  end
`else
  assign err_s = 1'b0;
`endif

  // Next entry to present, wrapping at the end of a round.
  always_comb begin
    ent_nxt_s = ent_r + IDX_W'(1);
    if (ent_last_s) begin
      ent_nxt_s = '0;
    end else begin
      ent_nxt_s = ent_r + IDX_W'(1);
    end
  end

  // Batch buffer; contents are don't-care until fully loaded.
  always_ff @(posedge i_clk) begin
    if (in_acc_s) begin
      mem_r[load_cnt_r] <= i_pnt_scl_dat;
    end
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r       <= IDLE;
      load_cnt_r    <= '0;
      ent_r         <= '0;
      rnd_r         <= '0;
      i_pnt_scl_rdy <= 1'b0;
      o_pnt_scl_val <= 1'b0;
      o_pnt_scl_sop <= 1'b0;
      o_pnt_scl_eop <= 1'b0;
      o_pnt_scl_ctl <= '0;
      o_pnt_scl_dat <= '0;
    end else begin
      case (state_r)
        IDLE, LOAD: begin
          i_pnt_scl_rdy <= 1'b1;
          if (in_acc_s) begin
            if (err_s) begin
              state_r    <= IDLE;
              load_cnt_r <= '0;
            end else if (load_cnt_r == LAST_IDX) begin
              // Batch complete: present entry 0 on the very next cycle.
              // With a single-entry batch, entry 0 is the beat arriving now.
              state_r       <= REPLAY;
              load_cnt_r    <= '0;
              ent_r         <= '0;
              rnd_r         <= '0;
              i_pnt_scl_rdy <= 1'b0;
              o_pnt_scl_val <= 1'b1;
              o_pnt_scl_sop <= 1'b1;
              o_pnt_scl_eop <= 1'b1;
              o_pnt_scl_ctl <= '0;
              o_pnt_scl_dat <= (load_cnt_r == '0) ? i_pnt_scl_dat : mem_r[0];
            end else begin
              state_r    <= LOAD;
              load_cnt_r <= load_cnt_r + IDX_W'(1);
            end
          end
        end
        REPLAY: begin
          if (out_acc_s) begin
            if (ent_last_s && rnd_last_s) begin
              // Final beat taken; reopen the input in the same edge so a
              // following batch sees no idle gap.
              state_r       <= IDLE;
              ent_r         <= '0;
              rnd_r         <= '0;
              i_pnt_scl_rdy <= 1'b1;
              o_pnt_scl_val <= 1'b0;
              o_pnt_scl_sop <= 1'b0;
              o_pnt_scl_eop <= 1'b0;
              o_pnt_scl_ctl <= '0;
            end else begin
              ent_r         <= ent_nxt_s;
              o_pnt_scl_ctl <= CTL_BITS'(ent_nxt_s);
              o_pnt_scl_dat <= mem_r[ent_nxt_s];
              if (ent_last_s) begin
                rnd_r <= rnd_r + RND_W'(1);
              end
            end
          end
        end
        default: begin
          state_r       <= IDLE;
          load_cnt_r    <= '0;
          ent_r         <= '0;
          rnd_r         <= '0;
          i_pnt_scl_rdy <= 1'b0;
          o_pnt_scl_val <= 1'b0;
          o_pnt_scl_sop <= 1'b0;
          o_pnt_scl_eop <= 1'b0;
          o_pnt_scl_ctl <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiexp_feeder.sv
// ---------------------------------------------------------------------------
// tb_multiexp_feeder
//
// Randomised scoreboard bench for multiexp_feeder. The driver loads batches of
// random {point, scalar} pairs; once a batch is complete it pushes the whole
// expected replay (every round, every entry) into a queue. An independent
// monitor pops one expected beat per output handshake and compares it, and
// also checks that a stalled beat holds still.
// ---------------------------------------------------------------------------
module tb_multiexp_feeder;

  localparam int PNT_BITS = 768;
  localparam int SCL_BITS = 256;
  localparam int NUM_IN   = 4;
  localparam int CTL_BITS = 8;
  localparam int DW       = PNT_BITS + SCL_BITS;

  logic                clk = 1'b0;
  logic                rst;
  logic [DW-1:0]       in_dat;
  logic                in_val;
  logic                in_rdy;
  logic                in_sop;
  logic                in_eop;
  logic [CTL_BITS-1:0] in_ctl;
  logic [DW-1:0]       out_dat;
  logic                out_val;
  logic                out_rdy;
  logic                out_sop;
  logic                out_eop;
  logic [CTL_BITS-1:0] out_ctl;
  logic                busy;
`ifdef MULTIEXP_FEEDER_ERR_EN
  logic                err;
`endif

  multiexp_feeder #(
    .PNT_BITS(PNT_BITS),
    .SCL_BITS(SCL_BITS),
    .NUM_IN  (NUM_IN),
    .CTL_BITS(CTL_BITS)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pnt_scl_dat(in_dat),
    .i_pnt_scl_val(in_val),
    .i_pnt_scl_rdy(in_rdy),
    .i_pnt_scl_sop(in_sop),
    .i_pnt_scl_eop(in_eop),
    .i_pnt_scl_ctl(in_ctl),
    .o_pnt_scl_dat(out_dat),
    .o_pnt_scl_val(out_val),
    .o_pnt_scl_rdy(out_rdy),
    .o_pnt_scl_sop(out_sop),
    .o_pnt_scl_eop(out_eop),
    .o_pnt_scl_ctl(out_ctl),
`ifdef MULTIEXP_FEEDER_ERR_EN
    .o_err        (err),
`endif
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dat;
    int            ctl;
  } beat_t;

  beat_t         exp_q[$];
  int            checks     = 0;
  int            errors     = 0;
  int            beats_seen = 0;
  int            rdy_mode   = 0;   // 0: always ready, 1: random 50%
  logic [DW-1:0] pairs [NUM_IN];

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the batch is replayed SCL_BITS times, entries in order.
  task automatic push_expected();
    beat_t b;
    for (int r = 0; r < SCL_BITS; r++) begin
      for (int e = 0; e < NUM_IN; e++) begin
        b.dat = pairs[e];
        b.ctl = e;
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor: drives output backpressure and scores every output handshake.
  initial begin
    beat_t         e;
    logic          prev_stall;
    logic [DW-1:0] prev_dat;
    logic [CTL_BITS-1:0] prev_ctl;
    prev_stall = 1'b0;
    prev_dat   = '0;
    prev_ctl   = '0;
    out_rdy    = 1'b1;
    forever begin
      @(negedge clk);
      out_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rst !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {out_val, (out_dat === prev_dat), out_ctl},
                {1'b1, 1'b1, prev_ctl});
        end
        if (out_val === 1'b1 && out_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat ctl=%0d, expected none (t=%0t)", out_ctl, $time);
          end else begin
            e = exp_q.pop_front();
            check("beat_ctl", out_ctl, e.ctl);
            check("beat_sop_eop", {out_sop, out_eop}, 2'b11);
            checks++;
            if (out_dat !== e.dat) begin
              errors++;
              $display("FAIL beat_dat: got low bits %h, expected %h (ctl=%0d t=%0t)",
                       out_dat[127:0], e.dat[127:0], e.ctl, $time);
            end
            beats_seen++;
          end
        end
        prev_stall = (out_val === 1'b1) && !out_rdy;
        prev_dat   = out_dat;
        prev_ctl   = out_ctl;
      end
    end
  end

  // Offer n beats starting at the current negedge; eop on beat eop_at.
  // A full batch queues its expected replay just before its last beat lands.
  task automatic send_batch(input int n, input int eop_at, input bit full);
    logic [DW-1:0] d;
    bit got;
    for (int k = 0; k < n; k++) begin
      d      = rand_dat();
      in_dat = d;
      in_val = 1'b1;
      in_sop = (k == 0);
      in_eop = (k == eop_at);
      in_ctl = CTL_BITS'($urandom());
      if (k < NUM_IN) pairs[k] = d;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        if (in_rdy === 1'b1) begin
          got = 1'b1;
          if (full && k == n - 1) begin
            check("val_before_last_load", out_val, 1'b0);
            push_expected();
          end
        end
        @(negedge clk);
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: got no in_rdy, expected acceptance of beat %0d", k);
      end
      if (k == 0 && n > 1) check("busy_in_load", busy, 1'b1);
    end
    in_val = 1'b0;
    in_eop = 1'b0;
    if (full) begin
      check("first_val_latency", out_val, 1'b1);
      check("in_rdy_in_replay", in_rdy, 1'b0);
      check("busy_in_replay", busy, 1'b1);
    end
  endtask

  // Wait for the replay to drain; optionally keep offering input meanwhile.
  // Returns at the negedge one cycle after the final beat was taken.
  task automatic wait_done(input bit offer);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        if (offer) begin
          in_val = 1'b1;
          in_dat = rand_dat();
          check("in_rdy_low_replay", in_rdy, 1'b0);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL replay_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    @(negedge clk);
    in_val = 1'b0;
    check("end_val_low", out_val, 1'b0);
    check("end_in_rdy", in_rdy, 1'b1);
    check("end_busy_low", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bit hit;
    rst    = 1'b1;
    in_val = 1'b0;
    in_dat = '0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_ctl = '0;
    repeat (3) @(negedge clk);
    check("rst_out_val", out_val, 1'b0);
    check("rst_out_sop_eop", {out_sop, out_eop}, 2'b00);
    check("rst_out_ctl", out_ctl, 0);
    check("rst_out_dat_zero", (out_dat == '0), 1'b1);
    check("rst_in_rdy", in_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
`ifdef MULTIEXP_FEEDER_ERR_EN
    check("rst_err", err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", in_rdy, 1'b1);

    // Full-rate replay.
    rdy_mode = 0;
    send_batch(NUM_IN, -1, 1'b1);
    wait_done(1'b0);

    // Random output backpressure.
    rdy_mode = 1;
    send_batch(NUM_IN, NUM_IN - 1, 1'b1);
    wait_done(1'b0);

    // Input offered throughout replay, then taken right after it ends.
    rdy_mode = 0;
    send_batch(NUM_IN, -1, 1'b1);
    wait_done(1'b1);
    send_batch(NUM_IN, -1, 1'b1);
    wait_done(1'b0);

    // Reset during replay, then reload fresh data.
    rdy_mode = 1;
    send_batch(NUM_IN, -1, 1'b1);
    base = beats_seen;
    hit  = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(posedge clk);
      if (beats_seen >= base + 300) hit = 1'b1;
    end
    check("reach_beat_300", hit, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_val", out_val, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_rdy", in_rdy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_rdy", in_rdy, 1'b1);
    send_batch(NUM_IN, -1, 1'b1);
    wait_done(1'b0);

    // Back-to-back batches with no idle cycle between them.
    rdy_mode = 0;
    send_batch(NUM_IN, -1, 1'b1);
    wait_done(1'b0);
`ifdef MULTIEXP_FEEDER_ERR_EN
    send_batch(NUM_IN, NUM_IN - 1, 1'b1);
`else
    // Input eop carries no meaning here, even mid-batch.
    send_batch(NUM_IN, 1, 1'b1);
`endif
    wait_done(1'b0);

`ifdef MULTIEXP_FEEDER_ERR_EN
    // Short batch: eop on the second beat.
    send_batch(2, 1, 1'b0);
    check("err_set", err, 1'b1);
    check("err_busy_low", busy, 1'b0);
    check("err_no_val", out_val, 1'b0);
    check("err_in_rdy", in_rdy, 1'b1);
    repeat (4) @(negedge clk);
    check("err_still_no_val", out_val, 1'b0);
    send_batch(NUM_IN, NUM_IN - 1, 1'b1);
    wait_done(1'b0);
    check("err_sticky", err, 1'b1);
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
